hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
Parametrised HI/LO register pair with an attached iterative multiply/divide unit, for the MIPS datapath's MULT/MULTU/DIV/DIVU/MTHI/MTLO handling.
- Multiply: radix-2 shift-add, one bit per cycle.
- Divide: restoring, one bit per cycle.
- MTHI/MTLO write directly in one cycle.
- Busy drives the pipeline hazard unit, which stalls MFHI/MFLO and further MDU ops while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO register width (even, >= 4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  request; sampled on rising Clk edge, ignored while Busy=1
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
A  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
B  input  WIDTH  rt operand (divisor / multiplier)
Busy  output  1  high while state != IDLE (combinational from state register)
Done  output  1  registered one-cycle pulse on result write or divide-by-zero
DivByZero  output  1  registered one-cycle pulse, coincident with Done, for DIV/DIVU with B=0
HI  output  WIDTH  HI register contents
LO  output  WIDTH  LO register contents

Behaviour:
- Reset (Rst_n=0, asynchronous): state=IDLE, HI=0, LO=0, Done=0, DivByZero=0, counter=0. Reset mid-operation aborts the operation with no write.
- States: IDLE, CALC, FIX.
- Acceptance edge k (IDLE, Start=1), by Op:
  - MTHI/MTLO: HI<=A or LO<=A at edge k. State stays IDLE, no Done.
  - DIV/DIVU with B=0: HI/LO unchanged, state stays IDLE. Done=1 and DivByZero=1 for the cycle after edge k.
  - MULT/MULTU/DIV/DIVU otherwise:
    - Latch operand magnitudes (two's-complement abs for signed ops).
    - Latch result-sign flags: quotient/product sign = A[msb]^B[msb]; remainder sign = A[msb].
    - counter<=0, state<=CALC.
- CALC, edges k+1 .. k+WIDTH:
  - One iteration per edge, counter increments.
  - After the WIDTH-th iteration (counter==WIDTH-1 at that edge), state<=FIX.
- FIX, edge k+WIDTH+1:
  - Apply sign fixup and write HI/LO: mult HI=product[2W-1:W], LO=product[W-1:0]; div LO=quotient, HI=remainder.
  - Done=1 for the following cycle; state<=IDLE.
- Latency: result visible on HI/LO and Done high in the cycle after edge k+WIDTH+1.
  - Busy=1 for WIDTH+1 cycles (after edge k through edge k+WIDTH+1).
  - A new Start is accepted in the Done cycle.
- Start while Busy: ignored entirely (MTHI/MTLO included). HI/LO hold.
- Signed overflow, DIV with most-negative / -1: LO=most-negative, HI=0 (natural wrap, no flag).
- MULTU/DIVU treat operands as unsigned; no sign fixup.
- HI/LO change only at FIX edges, MTHI/MTLO edges, or reset; stable during CALC.
- Done and DivByZero never assert for more than one consecutive cycle per request.

Optional Feature:
HILO_MADD_EN
- Defined: Op 110 MADD (signed) and 111 MADDU (unsigned) run the multiply path with identical timing. At the FIX edge, {HI,LO} <= {HI,LO} + product (2*WIDTH-bit add, wrap, no overflow flag).
- Undefined: Op 110/111 are ignored in IDLE: no state change, no Done, HI/LO unchanged.

Test Plan:
1. Reset, then MULT A=0xFFFFFFFD (-3), B=7 -> Busy high 33 cycles; Done in cycle after edge k+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. DIVU A=100, B=7 -> LO=0x0000000E, HI=0x00000002. Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. MTHI A=0x12345678, MTLO A=0x9ABCDEF0, then DIV A=5, B=0 -> Done and DivByZero high one cycle after edge k; Busy never high; HI/LO remain 0x12345678/0x9ABCDEF0.
4. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF; MTHI A=0xDEAD0000 pulsed while Busy -> MTHI ignored; HI=0xFFFFFFFE, LO=0x00000001.
5. Start MULT A=6, B=7; drop Rst_n for one cycle at edge k+10 -> HI=LO=0, Busy=0 immediately, no Done; a subsequent MULT 6*7 gives LO=42.
6. With HILO_MADD_EN: MTHI 0, MTLO 5, then MADD A=2, B=3 -> LO=11, HI=0. Without HILO_MADD_EN: same Op 110 -> no Busy, no Done, LO=5.

Source files
------------

// File: rtl/hilo_mdu.sv
// HI/LO register pair with an iterative shift-add multiplier and restoring divider.
// Optional HILO_MADD_EN adds MADD/MADDU (accumulate the product into {HI,LO}).
module hilo_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // running remainder / upper product half
    logic [WIDTH-1:0]   quo_q, quo_d;     // dividend->quotient / multiplier->lower product half
    logic [WIDTH-1:0]   opb_q, opb_d;     // divisor / multiplicand magnitude
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
`ifdef HILO_MADD_EN
    logic               madd_q, madd_d;
`endif

    logic               op_sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               load_calc, load_div;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_sgn = ~Op[0];
    assign abs_a  = (op_sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign abs_b  = (op_sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;

    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);

    // neg_q/rneg_q are only ever set for signed ops, so unsigned results pass through.
    assign prod     = {rem_q, quo_q};
    assign prod_fix = neg_q  ? (~prod + 1'b1)  : prod;
    assign quo_fix  = neg_q  ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix  = rneg_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        load_calc = 1'b0;
        load_div  = 1'b0;
        if (state_q == IDLE && Start) begin
            case (Op)
                3'b000, 3'b001: load_calc = 1'b1;
                3'b010, 3'b011: begin
                    load_calc = (B != '0);
                    load_div  = (B != '0);
                end
`ifdef HILO_MADD_EN
                3'b110, 3'b111: load_calc = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
`ifdef HILO_MADD_EN
        madd_d   = madd_q;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Op == 3'b100) hi_d = A;
                    if (Op == 3'b101) lo_d = A;
                    if ((Op == 3'b010 || Op == 3'b011) && B == '0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end
                end
                if (load_calc) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    rem_d    = '0;
                    quo_d    = abs_a;
                    opb_d    = abs_b;
                    is_div_d = load_div;
                    neg_d    = op_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rneg_d   = op_sgn & A[WIDTH-1];
`ifdef HILO_MADD_EN
                    madd_d   = Op[2];
`endif
                end
            end

            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    if (div_shift >= {1'b0, opb_q}) begin
                        rem_d = div_shift[WIDTH-1:0] - opb_q;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_ITER) state_d = FIX;
            end

            FIX: begin
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
`ifdef HILO_MADD_EN
                    if (madd_q) {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
                    else        {hi_d, lo_d} = prod_fix;
`else
                    {hi_d, lo_d} = prod_fix;
`endif
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef HILO_MADD_EN
            madd_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
`ifdef HILO_MADD_EN
            madd_q   <= madd_d;
`endif
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu (WIDTH=32); define HILO_MADD_EN for both files to test MADD.
module tb_hilo_mdu;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;

    hilo_mdu #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drive a request from the current point; it is taken at the next rising edge.
    task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        issue_now(op, a, b);
    endtask

    // Returns at the falling edge where Done is seen, or after a cycle budget.
    task automatic wait_done(output int busy_cycles, output logic got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (Done) begin
                got_done = 1'b1;
                break;
            end
            if (Busy) busy_cycles++;
        end
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        Start = 1'b0;
        Op    = 3'b000;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {Busy, Done, DivByZero});
        end
        checks++;
        if ({HI, LO} !== 64'h0) begin
            failures++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", HI, LO);
        end
        Rst_n = 1'b1;
    endtask

    task automatic test_mult_signed;
        int   bc;
        logic gd;
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done(bc, gd);
        checks++;
        if (gd !== 1'b1) begin
            failures++;
            $display("FAIL mult_done: got %b expected 1", gd);
        end
        checks++;
        if (bc !== 33) begin
            failures++;
            $display("FAIL mult_busy_cycles: got %0d expected 33", bc);
        end
        checks++;
        if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFEB) begin
            failures++;
            $display("FAIL mult_neg3x7: got %h_%h expected ffffffff_ffffffeb", HI, LO);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL mult_done_pulse: got %b expected 0", Done);
        end
    endtask

    task automatic test_divide;
        int   bc;
        logic gd;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(bc, gd);
        checks++;
        if ({gd, DivByZero, HI, LO} !== {1'b1, 1'b0, 32'h2, 32'hE}) begin
            failures++;
            $display("FAIL divu_100_7: got done=%b dbz=%b %h_%h expected 1 0 00000002_0000000e", gd, DivByZero, HI, LO);
        end
        checks++;
        if (bc !== 33) begin
            failures++;
            $display("FAIL div_busy_cycles: got %0d expected 33", bc);
        end
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(bc, gd);
        checks++;
        if ({gd, HI, LO} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            failures++;
            $display("FAIL div_neg7_2: got done=%b %h_%h expected 1 ffffffff_fffffffd", gd, HI, LO);
        end
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(bc, gd);
        checks++;
        if ({gd, HI, LO} !== {1'b1, 32'h1, 32'hFFFFFFFD}) begin
            failures++;
            $display("FAIL div_7_neg2: got done=%b %h_%h expected 1 00000001_fffffffd", gd, HI, LO);
        end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(bc, gd);
        checks++;
        if ({gd, HI, LO} !== {1'b1, 32'h0, 32'h80000000}) begin
            failures++;
            $display("FAIL div_overflow: got done=%b %h_%h expected 1 00000000_80000000", gd, HI, LO);
        end
    endtask

    task automatic test_mt_divzero;
        int busy_seen;
        issue(OP_MTHI, 32'h12345678, 32'd0);
        issue(OP_MTLO, 32'h9ABCDEF0, 32'd0);
        @(negedge Clk);
        checks++;
        if ({HI, LO, Done} !== {32'h12345678, 32'h9ABCDEF0, 1'b0}) begin
            failures++;
            $display("FAIL mthi_mtlo: got %h_%h done=%b expected 12345678_9abcdef0 done=0", HI, LO, Done);
        end
        busy_seen = 0;
        issue(OP_DIV, 32'd5, 32'd0);
        @(negedge Clk);
        if (Busy) busy_seen++;
        checks++;
        if ({Done, DivByZero} !== 2'b11) begin
            failures++;
            $display("FAIL divzero_pulse: got done=%b dbz=%b expected 1 1", Done, DivByZero);
        end
        @(negedge Clk);
        if (Busy) busy_seen++;
        checks++;
        if ({Done, DivByZero} !== 2'b00) begin
            failures++;
            $display("FAIL divzero_one_cycle: got done=%b dbz=%b expected 0 0", Done, DivByZero);
        end
        checks++;
        if (busy_seen !== 0) begin
            failures++;
            $display("FAIL divzero_busy: got %0d busy cycles expected 0", busy_seen);
        end
        checks++;
        if ({HI, LO} !== {32'h12345678, 32'h9ABCDEF0}) begin
            failures++;
            $display("FAIL divzero_hilo: got %h_%h expected 12345678_9abcdef0", HI, LO);
        end
    endtask

    task automatic test_busy_ignore;
        int   bc;
        logic gd;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (3) @(negedge Clk);
        Start = 1'b1;
        Op    = OP_MTHI;
        A     = 32'hDEAD0000;
        @(negedge Clk);
        Start = 1'b0;
        checks++;
        if ({Busy, HI, LO} !== {1'b1, 32'h12345678, 32'h9ABCDEF0}) begin
            failures++;
            $display("FAIL hilo_stable_calc: got busy=%b %h_%h expected 1 12345678_9abcdef0", Busy, HI, LO);
        end
        wait_done(bc, gd);
        checks++;
        if ({gd, HI, LO} !== {1'b1, 32'hFFFFFFFE, 32'h00000001}) begin
            failures++;
            $display("FAIL multu_max: got done=%b %h_%h expected 1 fffffffe_00000001", gd, HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        int   bc;
        logic gd;
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done(bc, gd);
        checks++;
        if ({gd, HI, LO} !== {1'b1, 32'h0, 32'd15}) begin
            failures++;
            $display("FAIL b2b_first: got done=%b %h_%h expected 1 00000000_0000000f", gd, HI, LO);
        end
        issue_now(OP_DIVU, 32'd20, 32'd6);
        wait_done(bc, gd);
        checks++;
        if ({gd, bc, HI, LO} !== {1'b1, 32'd33, 32'd2, 32'd3}) begin
            failures++;
            $display("FAIL b2b_second: got done=%b busy=%0d %h_%h expected 1 33 00000002_00000003", gd, bc, HI, LO);
        end
    endtask

    task automatic test_reset_mid_op;
        int   bc;
        int   dones;
        logic gd;
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({Busy, HI, LO} !== {1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_abort: got busy=%b %h_%h expected 0 0_0", Busy, HI, LO);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done || Busy) dones++;
        end
        checks++;
        if ({dones, HI, LO} !== {32'd0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_no_done: got activity=%0d %h_%h expected 0 0_0", dones, HI, LO);
        end
        issue(OP_MULT, 32'd6, 32'd7);
        wait_done(bc, gd);
        checks++;
        if ({gd, HI, LO} !== {1'b1, 32'h0, 32'd42}) begin
            failures++;
            $display("FAIL mult_after_reset: got done=%b %h_%h expected 1 00000000_0000002a", gd, HI, LO);
        end
    endtask

    task automatic test_madd;
        int   bc;
        logic gd;
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd5, 32'd0);
`ifdef HILO_MADD_EN
        issue(OP_MADD, 32'd2, 32'd3);
        wait_done(bc, gd);
        checks++;
        if ({gd, bc, HI, LO} !== {1'b1, 32'd33, 32'h0, 32'd11}) begin
            failures++;
            $display("FAIL madd: got done=%b busy=%0d %h_%h expected 1 33 00000000_0000000b", gd, bc, HI, LO);
        end
        issue(OP_MADD, 32'hFFFFFFFF, 32'd20);
        wait_done(bc, gd);
        checks++;
        if ({gd, HI, LO} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFF7}) begin
            failures++;
            $display("FAIL madd_neg: got done=%b %h_%h expected 1 ffffffff_fffffff7", gd, HI, LO);
        end
`else
        issue(OP_MADD, 32'd2, 32'd3);
        wait_done(bc, gd);
        checks++;
        if ({gd, bc, HI, LO} !== {1'b0, 32'd0, 32'h0, 32'd5}) begin
            failures++;
            $display("FAIL madd_disabled: got done=%b busy=%0d %h_%h expected 0 0 00000000_00000005", gd, bc, HI, LO);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_divide();
        test_mt_divzero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
